// File: rtl/damage_accumulator.sv
// Two-stage hit pipeline: stage 1 decodes the attack word, stage 2 applies
// move staleness, invulnerability and saturation to per-player damage percent.
module damage_accumulator #(
   parameter int NUM_PLAYERS    = 4,
   parameter int PCT_W          = 10,
   parameter int MAX_PCT        = 999,
   parameter int INVULN_CYCLES  = 30,
   parameter int RESPAWN_INVULN = 120,
   parameter int STALE_DEPTH    = 4,
   localparam int IDX_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         hit_valid,
   input  logic [IDX_W-1:0]             hit_attacker,
   input  logic [IDX_W-1:0]             hit_target,
   input  logic [31:0]                  attack,
   input  logic [NUM_PLAYERS-1:0]       clear_player,
   output logic [NUM_PLAYERS*PCT_W-1:0] damage_pct,
   output logic [NUM_PLAYERS-1:0]       invuln,
   output logic                         hit_event,
   output logic                         hit_blocked,
   output logic [IDX_W-1:0]             hit_who,
   output logic [PCT_W-1:0]             hit_amount
);
   localparam int CNT_MAX = (INVULN_CYCLES > RESPAWN_INVULN) ? INVULN_CYCLES : RESPAWN_INVULN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INVULN_LOAD  = CNT_W'(INVULN_CYCLES);
   localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_INVULN);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [PCT_W:0]   MAX_EXT      = (PCT_W+1)'(MAX_PCT);

   typedef logic [2:0] move_t;

   logic             s1_valid_q;
   logic [IDX_W-1:0] s1_att_q, s1_tgt_q;
   move_t            s1_move_q, move_d;
   logic [4:0]       s1_base_q, base_d;

   logic [PCT_W-1:0] pct_q  [NUM_PLAYERS];
   logic [CNT_W-1:0] cnt_q  [NUM_PLAYERS];
   move_t            hist_q [NUM_PLAYERS][STALE_DEPTH];

   logic             hit_event_q, hit_blocked_q;
   logic [IDX_W-1:0] hit_who_q;
   logic [PCT_W-1:0] hit_amount_q;

   logic             in_range, apply, block;
   logic [2:0]       stale_n;
   logic [7:0]       dmg;
   logic [PCT_W:0]   sum;
   logic [PCT_W-1:0] tgt_pct, new_pct;

   // Only the hit flag and the move field carry meaning.
   logic attack_unused;
   assign attack_unused = ^{attack[31:11], attack[4:1]};

   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      move_d = 3'd0;
      base_d = 5'd0;
      if (attack[0]) begin
         if (attack[5])                   begin move_d = 3'd1; base_d = 5'd5;  end
         else if (attack[6])              begin move_d = 3'd2; base_d = 5'd20; end
         else if (attack[7])              begin move_d = 3'd3; base_d = 5'd15; end
         else if (attack[8] | attack[9])  begin move_d = 3'd4; base_d = 5'd30; end
         else if (attack[10])             begin move_d = 3'd5; base_d = 5'd10; end
      end
   end

   always_comb begin
      in_range = (32'(s1_att_q) < NUM_PLAYERS) && (32'(s1_tgt_q) < NUM_PLAYERS);
      tgt_pct  = '0;
      stale_n  = '0;
      apply    = 1'b0;
      block    = 1'b0;
      if (in_range) begin
         tgt_pct = pct_q[s1_tgt_q];
         for (int j = 0; j < STALE_DEPTH; j++)
            if (hist_q[s1_att_q][j] == s1_move_q) stale_n = stale_n + 3'd1;
      end
      if (s1_valid_q) begin
         if (s1_move_q == 3'd0 || s1_att_q == s1_tgt_q || !in_range ||
             cnt_q[s1_tgt_q] != '0 || clear_player[s1_tgt_q])
            block = 1'b1;
         else
            apply = 1'b1;
      end
      // Staleness never exceeds 7/8 of base, so dmg cannot underflow.
      dmg     = {3'b000, s1_base_q} - ((8'(s1_base_q) * 8'(stale_n)) >> 3);
      sum     = (PCT_W+1)'(tgt_pct) + (PCT_W+1)'(dmg);
      new_pct = (sum > MAX_EXT) ? MAX_EXT[PCT_W-1:0] : sum[PCT_W-1:0];
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only; the small
      // per-player arrays are plain flops, so they are reset like any register.
      if (reset) begin
         s1_valid_q    <= 1'b0;
         s1_att_q      <= '0;
         s1_tgt_q      <= '0;
         s1_move_q     <= '0;
         s1_base_q     <= '0;
         hit_event_q   <= 1'b0;
         hit_blocked_q <= 1'b0;
         hit_who_q     <= '0;
         hit_amount_q  <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            pct_q[i] <= '0;
            cnt_q[i] <= '0;
            for (int j = 0; j < STALE_DEPTH; j++) hist_q[i][j] <= '0;
         end
      end else begin
         s1_valid_q <= hit_valid;
         if (hit_valid) begin
            s1_att_q  <= hit_attacker;
            s1_tgt_q  <= hit_target;
            s1_move_q <= move_d;
            s1_base_q <= base_d;
         end
         hit_event_q   <= apply;
         hit_blocked_q <= block;
         if (s1_valid_q) begin
            hit_who_q    <= s1_tgt_q;
            hit_amount_q <= apply ? (new_pct - tgt_pct) : '0;
         end
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            // A clear wins over everything touching that player this cycle.
            if (clear_player[i]) begin
               pct_q[i] <= '0;
               cnt_q[i] <= RESPAWN_LOAD;
               for (int j = 0; j < STALE_DEPTH; j++) hist_q[i][j] <= '0;
            end else begin
               if (apply && 32'(s1_tgt_q) == i) begin
                  pct_q[i] <= new_pct;
                  cnt_q[i] <= INVULN_LOAD;
               end else if (cnt_q[i] != '0) begin
                  cnt_q[i] <= cnt_q[i] - CNT_ONE;
               end
               if (apply && 32'(s1_att_q) == i) begin
                  for (int j = STALE_DEPTH - 1; j > 0; j--) hist_q[i][j] <= hist_q[i][j-1];
                  hist_q[i][0] <= s1_move_q;
               end
            end
         end
      end
   end

   always_comb begin
      damage_pct = '0;
      invuln     = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         damage_pct[i*PCT_W +: PCT_W] = pct_q[i];
         invuln[i]                    = (cnt_q[i] != '0);
      end
   end

   assign hit_event   = hit_event_q;
   assign hit_blocked = hit_blocked_q;
   assign hit_who     = hit_who_q;
   assign hit_amount  = hit_amount_q;

endmodule

// File: tb/tb_damage_accumulator.sv
// Random and directed stimulus for damage_accumulator, checked against a
// cycle-level reference model built from the damage/invulnerability rules.
module tb_damage_accumulator;
   localparam int NP      = 4;
   localparam int PCT_W   = 10;
   localparam int MAX     = 999;
   localparam int INVULN  = 30;
   localparam int RESPAWN = 120;
   localparam int DEPTH   = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             hit_valid = 1'b0;
   logic [1:0]       hit_attacker = '0, hit_target = '0;
   logic [31:0]      attack = '0;
   logic [NP-1:0]    clear_player = '0;
   logic [NP*PCT_W-1:0] damage_pct;
   logic [NP-1:0]    invuln;
   logic             hit_event, hit_blocked;
   logic [1:0]       hit_who;
   logic [PCT_W-1:0] hit_amount;

   // Second instance with a low ceiling to exercise saturation quickly.
   logic             s_reset = 1'b1, s_valid = 1'b0;
   logic [1:0]       s_att = '0, s_tgt = '0;
   logic [31:0]      s_attack = '0;
   logic [NP-1:0]    s_clear = '0;
   logic [NP*PCT_W-1:0] s_pct;
   logic [NP-1:0]    s_inv;
   logic             s_ev, s_bl;
   logic [1:0]       s_who;
   logic [PCT_W-1:0] s_amt;

   always #5 clock = ~clock;

   damage_accumulator u_dut (
      .clock(clock), .reset(reset), .hit_valid(hit_valid), .hit_attacker(hit_attacker),
      .hit_target(hit_target), .attack(attack), .clear_player(clear_player),
      .damage_pct(damage_pct), .invuln(invuln), .hit_event(hit_event),
      .hit_blocked(hit_blocked), .hit_who(hit_who), .hit_amount(hit_amount));

   damage_accumulator #(.MAX_PCT(40)) u_sat (
      .clock(clock), .reset(s_reset), .hit_valid(s_valid), .hit_attacker(s_att),
      .hit_target(s_tgt), .attack(s_attack), .clear_player(s_clear),
      .damage_pct(s_pct), .invuln(s_inv), .hit_event(s_ev),
      .hit_blocked(s_bl), .hit_who(s_who), .hit_amount(s_amt));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int m_pct [NP];
   int m_cnt [NP];
   int m_hist [NP][$];
   bit p_v;
   int p_att, p_tgt, p_id, p_base;
   bit m_ev, m_bl;
   int m_who, m_amt;

   function automatic void decode_attack(input logic [31:0] a, output int id, output int base);
      id = 0; base = 0;
      if (a[0] && a[5])                 begin id = 1; base = 5;  end
      else if (a[0] && a[6])            begin id = 2; base = 20; end
      else if (a[0] && a[7])            begin id = 3; base = 15; end
      else if (a[0] && (a[8] || a[9]))  begin id = 4; base = 30; end
      else if (a[0] && a[10])           begin id = 5; base = 10; end
   endfunction

   task automatic model_edge(input bit v, input int att, input int tgt, input logic [31:0] atk,
                             input logic [NP-1:0] clr, input bit rst);
      int n, dmg, nw;
      bit applied;
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            m_pct[i] = 0; m_cnt[i] = 0; m_hist[i].delete();
         end
         p_v = 0; m_ev = 0; m_bl = 0; m_who = 0; m_amt = 0;
         return;
      end
      m_ev = 0; m_bl = 0; applied = 0;
      if (p_v) begin
         m_who = p_tgt;
         if (p_id == 0 || p_att == p_tgt || m_cnt[p_tgt] != 0 || clr[p_tgt]) begin
            m_bl = 1; m_amt = 0;
         end else begin
            n = 0;
            for (int j = 0; j < m_hist[p_att].size(); j++)
               if (m_hist[p_att][j] == p_id) n++;
            dmg = p_base - (p_base * n) / 8;
            if (dmg < 0) dmg = 0;
            nw = m_pct[p_tgt] + dmg;
            if (nw > MAX) nw = MAX;
            m_amt = nw - m_pct[p_tgt];
            m_pct[p_tgt] = nw;
            m_ev = 1; applied = 1;
            m_hist[p_att].push_front(p_id);
            if (m_hist[p_att].size() > DEPTH) void'(m_hist[p_att].pop_back());
         end
      end
      for (int i = 0; i < NP; i++) begin
         if (clr[i]) begin
            m_pct[i] = 0; m_cnt[i] = RESPAWN; m_hist[i].delete();
         end else if (applied && p_tgt == i) m_cnt[i] = INVULN;
         else if (m_cnt[i] > 0) m_cnt[i]--;
      end
      p_v = v;
      if (v) begin
         p_att = att; p_tgt = tgt;
         decode_attack(atk, p_id, p_base);
      end
   endtask

   function automatic int pct_of(input int i);
      return int'(damage_pct[i*PCT_W +: PCT_W]);
   endfunction

   task automatic compare_all();
      for (int i = 0; i < NP; i++) begin
         check($sformatf("pct%0d", i), pct_of(i), m_pct[i]);
         check($sformatf("invuln%0d", i), invuln[i], m_cnt[i] != 0);
      end
      check("hit_event", hit_event, m_ev);
      check("hit_blocked", hit_blocked, m_bl);
      if (m_ev || m_bl) check("hit_who", hit_who, m_who);
      if (m_ev) check("hit_amount", hit_amount, m_amt);
   endtask

   task automatic step(input bit v, input int att, input int tgt, input logic [31:0] atk,
                       input logic [NP-1:0] clr, input bit rst);
      @(negedge clock);
      hit_valid    = v;
      hit_attacker = 2'(att);
      hit_target   = 2'(tgt);
      attack       = atk;
      clear_player = clr;
      reset        = rst;
      @(posedge clock);
      model_edge(v, att, tgt, atk, clr, rst);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 32'h0, '0, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 32'h0, '0, 1);
      step(0, 0, 0, 32'h0, '0, 1);
   endtask

   int exp3 [5] = '{30, 27, 23, 19, 15};
   int s_exp_pct [4] = '{20, 38, 40, 40};
   int s_exp_amt [4] = '{20, 18, 2, 0};

   initial begin
      // Reset state
      do_reset();
      check("rst_event", hit_event, 0);
      check("rst_amount", hit_amount, 0);

      // Single hit: P0 -> P1 with move 1 (base 5)
      step(1, 0, 1, 32'h21, '0, 0);
      idle(1);
      check("t1_pct1", pct_of(1), 5);
      check("t1_event", hit_event, 1);
      check("t1_amount", hit_amount, 5);
      check("t1_invuln1", invuln[1], 1);

      // Repeat inside the invulnerability window is dropped
      step(1, 0, 1, 32'h21, '0, 0);
      idle(1);
      check("t2_blocked", hit_blocked, 1);
      check("t2_who", hit_who, 1);
      check("t2_pct1", pct_of(1), 5);
      idle(30);
      step(1, 0, 1, 32'h21, '0, 0);
      idle(1);
      check("t2_late_event", hit_event, 1);
      check("t2_late_pct1", pct_of(1), 10);

      // Staleness decay with the same move from the same attacker
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 2, 32'h101, '0, 0);
         idle(1);
         check($sformatf("t3_amount%0d", k), hit_amount, exp3[k]);
         idle(40);
      end

      // Clear in the same cycle as a stage-2 hit on the same player
      do_reset();
      step(1, 2, 1, 32'h81, '0, 0);
      idle(40);
      step(1, 0, 1, 32'h21, '0, 0);
      step(0, 0, 0, 32'h0, 4'b0010, 0);
      check("t5_blocked", hit_blocked, 1);
      check("t5_pct1", pct_of(1), 0);
      idle(119);
      check("t5_invuln_held", invuln[1], 1);
      idle(1);
      check("t5_invuln_done", invuln[1], 0);

      // Reset one edge after hit_valid discards the in-flight hit
      step(1, 0, 3, 32'h21, '0, 0);
      step(0, 0, 0, 32'h0, '0, 1);
      check("t6_pct0", damage_pct, 0);
      check("t6_who", hit_who, 0);
      check("t6_amount", hit_amount, 0);
      idle(1);
      check("t6_no_event", hit_event, 0);
      step(1, 0, 1, 32'h01, '0, 0);
      idle(1);
      check("t6_id0_blocked", hit_blocked, 1);
      step(1, 2, 2, 32'h21, '0, 0);
      idle(1);
      check("t6_self_blocked", hit_blocked, 1);
      check("t6_self_event", hit_event, 0);

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] a;
         logic [NP-1:0] clr;
         int sel;
         sel = $urandom_range(0, 3);
         case (sel)
            0: a = $urandom();
            1: a = (32'h1 << $urandom_range(5, 10)) | 32'($urandom_range(0, 1));
            2: a = 32'h1 | (32'h1 << $urandom_range(5, 10)) | ($urandom() & 32'hFFFF_F81E);
            default: a = $urandom() & 32'hFFFF_F81F;
         endcase
         for (int i = 0; i < NP; i++) clr[i] = ($urandom_range(0, 99) == 0);
         step($urandom_range(0, 1) == 1, $urandom_range(0, NP - 1), $urandom_range(0, NP - 1),
              a, clr, $urandom_range(0, 499) == 0);
      end

      // Saturation at a low ceiling: P1 -> P3 with move 2 (base 20)
      @(negedge clock);
      s_reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         s_valid = 1'b1; s_att = 2'd1; s_tgt = 2'd3; s_attack = 32'h41;
         @(negedge clock);
         s_valid = 1'b0;
         @(posedge clock);
         #1;
         check($sformatf("sat_event%0d", k), s_ev, 1);
         check($sformatf("sat_blocked%0d", k), s_bl, 0);
         check($sformatf("sat_amount%0d", k), s_amt, s_exp_amt[k]);
         check($sformatf("sat_pct%0d", k), s_pct[3*PCT_W +: PCT_W], s_exp_pct[k]);
         repeat (40) @(negedge clock);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
